// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding is fixed; 2'd3 is unused and recovers to IDLE.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared by the adder datapaths.
// Purely combinational.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles,
// operands shifted LSB first, result built from the top down.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  import serial_add_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x     (a_q[0]),
    .y     (b_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_d    = {fa_s, sh_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // Final bit: publish the completed word in the same edge.
        if (cnt_q == LAST) begin
          sum_d   = sh_d;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that reuses one instance of the team's one-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands.
- Sequences operand shifting, carry feedback and result capture with a start/busy/done handshake.
- Sits beside the combinational adder cells as the area-minimal alternative to a ripple-carry chain.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- c_in  input  1  initial carry; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds its value until the next accepted start.
- c_out  output  1  final carry; holds its value until the next accepted start.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE.
  - busy=0, done=0, sum=0, c_out=0.
  - Internal shift registers, carry flop and counter are all 0.
- All outputs are registered. There is no combinational path from any input to any output.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at a clock edge loads a_sh<=a, b_sh<=b, carry<=c_in and cnt<=0.
  - The same edge moves state to RUN and sets busy<=1.
  - start=0 keeps state IDLE.
- RUN, on each edge:
  - The full-adder cell is fed x=a_sh[0], y=b_sh[0], c_in=carry.
  - sum_sh<={fa_s, sum_sh[WIDTH-1:1]}, so the result is built LSB first.
  - a_sh and b_sh shift right by one, with 0 shifted in.
  - carry<=fa_c_out and cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge, that edge processes the final bit, and state moves to DONE.
  - On the same edge: sum<=final sum_sh, c_out<=fa_c_out, done<=1.
- DONE:
  - Lasts exactly one cycle. done=1 and busy=1.
  - The next edge sets done<=0 and busy<=0, and state returns to IDLE.
- Latency: start is accepted at edge 0, and done is high during the cycle after edge WIDTH. Minimum start-to-start spacing is WIDTH+2 edges.
- start is ignored in RUN and DONE. It is not queued, and a/b/c_in changes during RUN have no effect.
- Arithmetic: {c_out, sum} = a + b + c_in, computed modulo 2^(WIDTH+1). There is no overflow flag.
- sum and c_out change only on the final RUN edge or on reset. Intermediate bits are never visible on sum.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. No done pulse is produced, and the outputs are zeroed.
- start held high continuously starts a new operation on the first edge after returning to IDLE.

Decomposition:
- Shared package serial_add_pkg:
  - State encoding localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - 2'd3 is illegal and recovers to IDLE on the next edge.
- One sub-module instance: the existing one-bit cell full_adder, instantiated once as u_fa.
- No new sub-module is written. FSM, shift registers and counter live in serial_add_ctrl.

Test Plan:
- a=8'h0F, b=8'h01, c_in=0, start pulsed 1 cycle -> busy rises after edge 0; done is high only in the cycle after edge 8; sum=8'h10, c_out=0.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Then a=8'h7F, b=8'h80, c_in=1 -> sum=8'h00, c_out=1.
- During RUN of a=8'h03+b=8'h04, pulse start with a=8'hAA, b=8'h55 -> the pulse is ignored; result sum=8'h07, c_out=0; exactly one done pulse.
- Assert rst at edge 4 of RUN -> busy, done, sum and c_out go to 0 asynchronously with no done pulse; a new start after release gives the correct result.
- start held high for 30 cycles with a=8'h01, b=8'h01 -> done pulses every 10 cycles; sum=8'h02 stays stable between pulses.
- Randomised 200 operations, WIDTH=8 and WIDTH=16 -> every {c_out,sum} equals a+b+c_in, and done spacing is WIDTH+2 under continuous start.
